// File: rtl/cdb_arbiter_if.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_if
//   Bundles the producer request side and the common data bus broadcast side
//   of the CDB arbiter.
//   master : producers / reorder buffer side (drives requests and clear)
//   slave  : the arbiter (drives reqReady and the cdb* broadcast)
//   Signals:
//     clear        flush from the reorder buffer (branch mispredict)
//     reqValid     producer i presents a result
//     reqRobIndex  ROB index, producer i at [i*ROB_WIDTH +: ROB_WIDTH]
//     reqValue     result value, producer i at [i*32 +: 32]
//     reqReady     slot i can accept this cycle
//     cdbValid     broadcast valid
//     cdbRobIndex  broadcast ROB index
//     cdbValue     broadcast value
//     cdbSource    one-hot id of the producer being broadcast
// -----------------------------------------------------------------------------
interface cdb_arbiter_if #(
  parameter int ROB_WIDTH = 4,
  parameter int NUM_REQ   = 2
);
  logic                          clear;
  logic [NUM_REQ-1:0]            reqValid;
  logic [NUM_REQ*ROB_WIDTH-1:0]  reqRobIndex;
  logic [NUM_REQ*32-1:0]         reqValue;
  logic [NUM_REQ-1:0]            reqReady;
  logic                          cdbValid;
  logic [ROB_WIDTH-1:0]          cdbRobIndex;
  logic [31:0]                   cdbValue;
  logic [NUM_REQ-1:0]            cdbSource;

  modport master (
    output clear, reqValid, reqRobIndex, reqValue,
    input  reqReady, cdbValid, cdbRobIndex, cdbValue, cdbSource
  );

  modport slave (
    input  clear, reqValid, reqRobIndex, reqValue,
    output reqReady, cdbValid, cdbRobIndex, cdbValue, cdbSource
  );
endinterface

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//   Shares the single result-broadcast bus (CDB) between result producers
//   (index 0 = reservation station/ALU, index 1 = load & store buffer).
//   Each producer owns a 1-entry holding slot; one slot is granted per cycle,
//   round-robin, and its contents are registered onto the CDB.
//
//   Ports:
//     clockIn   clock
//     resetIn   synchronous active-high reset
//     bus       cdb_arbiter_if.slave (requests, clear, reqReady, cdb* outputs)
//
//   Configuration:
//     CDB_FIXED_PRIORITY_EN  when defined, the round-robin pointer is removed
//                            and the lowest valid slot always wins (debug only;
//                            higher indices can starve).
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int ROB_WIDTH = 4,
  parameter int NUM_REQ   = 2,
  parameter int PTR_WIDTH = 1
) (
  input  logic          clockIn,
  input  logic          resetIn,
  cdb_arbiter_if.slave  bus
);

  // Holding slots, one per producer.
  logic [NUM_REQ-1:0]    r_slot_valid;
  logic [ROB_WIDTH-1:0]  r_slot_rob [NUM_REQ];
  logic [31:0]           r_slot_val [NUM_REQ];

`ifndef CDB_FIXED_PRIORITY_EN
  logic [PTR_WIDTH-1:0]  r_rr_ptr;
`endif

  // Registered broadcast.
  logic                  r_cdb_valid;
  logic [ROB_WIDTH-1:0]  r_cdb_rob;
  logic [31:0]           r_cdb_val;
  logic [NUM_REQ-1:0]    r_cdb_src;

  logic [NUM_REQ-1:0]    w_grant;
  logic [NUM_REQ-1:0]    w_ready;
  logic [NUM_REQ-1:0]    w_accept;
  logic                  w_any;
  logic [PTR_WIDTH-1:0]  w_win_idx;
  logic [ROB_WIDTH-1:0]  w_win_rob;
  logic [31:0]           w_win_val;

  function automatic int rr_index(input int base, input int k);
    return (base + k) % NUM_REQ;
  endfunction

  // Grant: first valid slot at or after the pointer, scanning upward.
  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_grant   = '0;
    w_win_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef CDB_FIXED_PRIORITY_EN
      if (w_grant == '0 && r_slot_valid[k]) begin
        w_grant[k] = 1'b1;
        w_win_idx  = PTR_WIDTH'(k);
      end
`else
      if (w_grant == '0 && r_slot_valid[rr_index(int'(r_rr_ptr), k)]) begin
        w_grant[rr_index(int'(r_rr_ptr), k)] = 1'b1;
        w_win_idx = PTR_WIDTH'(rr_index(int'(r_rr_ptr), k));
      end
`endif
    end
    w_any     = |w_grant;
    w_win_rob = r_slot_rob[w_win_idx];
    w_win_val = r_slot_val[w_win_idx];
  end

  // A slot being drained this cycle can be refilled in the same cycle.
  // During clear everything is flushed, so every slot reports ready.
  assign w_ready  = ~r_slot_valid | w_grant | {NUM_REQ{bus.clear}};
  assign w_accept = bus.reqValid & w_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      r_slot_valid <= '0;
      r_cdb_valid  <= 1'b0;
      r_cdb_rob    <= '0;
      r_cdb_val    <= '0;
      r_cdb_src    <= '0;
`ifndef CDB_FIXED_PRIORITY_EN
      r_rr_ptr     <= '0;
`endif
    end else if (bus.clear) begin
      // Flush: data registers keep their last value, only control is cleared.
      r_slot_valid <= '0;
      r_cdb_valid  <= 1'b0;
      r_cdb_src    <= '0;
`ifndef CDB_FIXED_PRIORITY_EN
      r_rr_ptr     <= '0;
`endif
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_accept[i])
          r_slot_valid[i] <= 1'b1;
        else if (w_grant[i])
          r_slot_valid[i] <= 1'b0;
      end
      r_cdb_valid <= w_any;
      if (w_any) begin
        r_cdb_rob <= w_win_rob;
        r_cdb_val <= w_win_val;
        r_cdb_src <= w_grant;
`ifndef CDB_FIXED_PRIORITY_EN
        r_rr_ptr  <= PTR_WIDTH'((int'(w_win_idx) + 1) % NUM_REQ);
`endif
      end
    end
  end

  // NOTE: slot payload is qualified by r_slot_valid, so it is left out of
  // reset; keeping it in the reset block would turn reset into a data enable.
  always_ff @(posedge clockIn) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_accept[i]) begin
        r_slot_rob[i] <= bus.reqRobIndex[i*ROB_WIDTH +: ROB_WIDTH];
        r_slot_val[i] <= bus.reqValue[i*32 +: 32];
      end
    end
  end

  assign bus.reqReady    = w_ready;
  assign bus.cdbValid    = r_cdb_valid;
  assign bus.cdbRobIndex = r_cdb_rob;
  assign bus.cdbValue    = r_cdb_val;
  assign bus.cdbSource   = r_cdb_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//   Scoreboard bench for cdb_arbiter. The driver offers results from per-
//   producer queues, keeps a small reference model of the holding slots and
//   arbitration rule, and pushes each predicted broadcast (source, index,
//   value, edge) into exp_q. An independent monitor pops exp_q whenever the
//   DUT broadcasts and flags unexpected, missing or wrong results.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;
  localparam int RW = 4;
  localparam int NR = 2;

  typedef struct {
    logic [RW-1:0] rob;
    logic [31:0]   val;
  } item_t;

  typedef struct {
    int            src;
    logic [RW-1:0] rob;
    logic [31:0]   val;
    int            edge_n;
  } exp_t;

  logic clockIn = 1'b0;
  logic resetIn;
  always #5 clockIn = ~clockIn;

  cdb_arbiter_if #(.ROB_WIDTH(RW), .NUM_REQ(NR)) bus ();

  cdb_arbiter #(.ROB_WIDTH(RW), .NUM_REQ(NR), .PTR_WIDTH(1)) dut (
    .clockIn (clockIn),
    .resetIn (resetIn),
    .bus     (bus)
  );

  int    vectors    = 0;
  int    miscompares = 0;
  int    edge_cnt   = 0;
  item_t src_q [NR][$];
  exp_t  exp_q [$];
  exp_t  mon_e;

  // Reference model: which producers hold an undelivered result, and the
  // round-robin starting point.
  bit [NR-1:0]   m_pend;
  logic [RW-1:0] m_rob [NR];
  logic [31:0]   m_val [NR];
  int            m_ptr;

  always @(posedge clockIn) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp_v, edge_cnt);
    end
  endtask

  function automatic int model_winner();
    for (int k = 0; k < NR; k++) begin
`ifdef CDB_FIXED_PRIORITY_EN
      if (m_pend[k]) return k;
`else
      if (m_pend[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
`endif
    end
    return -1;
  endfunction

  // Monitor: independent of the driver, consumes predictions on broadcasts.
  always @(negedge clockIn) begin
    if (bus.cdbValid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_bcast", 64'(bus.cdbSource), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("cdb_source", 64'(bus.cdbSource), 64'(1 << mon_e.src));
        check("cdb_rob",    64'(bus.cdbRobIndex), 64'(mon_e.rob));
        check("cdb_value",  64'(bus.cdbValue), 64'(mon_e.val));
        check("cdb_edge",   64'(edge_cnt), 64'(mon_e.edge_n));
      end
    end else if (exp_q.size() > 0 && exp_q[0].edge_n <= edge_cnt) begin
      mon_e = exp_q.pop_front();
      check("missing_bcast", 64'(bus.cdbValid), 64'd1);
    end
  end

  // One clock cycle: drive at negedge, predict, advance to next negedge.
  task automatic step(input bit clr, input bit rst, input int density);
    logic [NR-1:0] v, rdy, hs;
    int w;
    for (int i = 0; i < NR; i++) begin
      v[i] = (src_q[i].size() > 0) && (int'($urandom_range(99)) < density);
      if (src_q[i].size() > 0) begin
        bus.reqRobIndex[i*RW +: RW] = src_q[i][0].rob;
        bus.reqValue[i*32 +: 32]    = src_q[i][0].val;
      end else begin
        bus.reqRobIndex[i*RW +: RW] = RW'($urandom);
        bus.reqValue[i*32 +: 32]    = $urandom;
      end
    end
    bus.reqValid = v;
    bus.clear    = clr;
    resetIn      = rst;
    #1;
    w = model_winner();
    for (int i = 0; i < NR; i++) rdy[i] = !m_pend[i] || (w == i) || clr;
    if (!rst) check("reqReady", 64'(bus.reqReady), 64'(rdy));
    hs = rst ? '0 : (v & rdy);
    if (rst || clr) begin
      m_pend = '0;
      m_ptr  = 0;
    end else begin
      if (w >= 0) begin
        exp_q.push_back('{src: w, rob: m_rob[w], val: m_val[w], edge_n: edge_cnt + 1});
        m_pend[w] = 1'b0;
        m_ptr     = (w + 1) % NR;
      end
      for (int i = 0; i < NR; i++) begin
        if (hs[i]) begin
          m_pend[i] = 1'b1;
          m_rob[i]  = src_q[i][0].rob;
          m_val[i]  = src_q[i][0].val;
        end
      end
    end
    for (int i = 0; i < NR; i++) if (hs[i]) void'(src_q[i].pop_front());
    @(posedge clockIn);
    @(negedge clockIn);
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while ((src_q[0].size() > 0 || src_q[1].size() > 0 || m_pend != '0) && n < max_cycles) begin
      step(1'b0, 1'b0, 100);
      n++;
    end
    if (n >= max_cycles) check("drain_timeout", 64'd1, 64'd0);
    step(1'b0, 1'b0, 100);
    step(1'b0, 1'b0, 100);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},  64'(bus.cdbValid), 64'd0);
    check({tag, "_rob"},    64'(bus.cdbRobIndex), 64'd0);
    check({tag, "_value"},  64'(bus.cdbValue), 64'd0);
    check({tag, "_source"}, 64'(bus.cdbSource), 64'd0);
  endtask

  task automatic push_item(input int p, input int rob, input logic [31:0] val);
    src_q[p].push_back('{rob: RW'(rob), val: val});
  endtask

  initial begin
    bus.clear       = 1'b0;
    bus.reqValid    = '0;
    bus.reqRobIndex = '0;
    bus.reqValue    = '0;
    resetIn         = 1'b1;
    m_pend          = '0;
    m_ptr           = 0;
    @(negedge clockIn);

    // Reset, then idle.
    step(1'b0, 1'b1, 0);
    step(1'b0, 1'b1, 0);
    check_reset_outputs("reset");
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b0, 100);
      check("idle_valid", 64'(bus.cdbValid), 64'd0);
    end

    // Single result from P0: two-edge latency, one-cycle pulse.
    push_item(0, 3, 32'h11);
    step(1'b0, 1'b0, 100);
    step(1'b0, 1'b0, 100);
    step(1'b0, 1'b0, 100);

    // Both producers streaming: alternating grants, per-source order.
    for (int r = 1; r <= 6; r++) begin
      push_item(0, r, 32'h100 + 32'(r));
      push_item(1, r + 8, 32'h200 + 32'(r + 8));
    end
    drain(100);

    // Fill both slots, then clear with a new P1 request: all dropped.
    push_item(0, 5, 32'hA5);
    push_item(1, 6, 32'hB6);
    step(1'b0, 1'b0, 100);
    push_item(1, 7, 32'hC7);
    step(1'b1, 1'b0, 100);
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 100);
    // Pointer back at 0: simultaneous arrivals go P0 first.
    push_item(1, 2, 32'hD2);
    push_item(0, 1, 32'hE1);
    drain(20);

    // P1 waiting while P0 streams four results.
    for (int r = 0; r < 4; r++) push_item(0, r, 32'h300 + 32'(r));
    push_item(1, 15, 32'h3FF);
    drain(40);

    // Reset in the middle of a stream.
    for (int r = 0; r < 6; r++) begin
      push_item(0, r, 32'h400 + 32'(r));
      push_item(1, r + 8, 32'h500 + 32'(r));
    end
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 100);
    step(1'b0, 1'b1, 100);
    check_reset_outputs("midreset");
    drain(100);

    // Randomized traffic with occasional clears.
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < NR; p++)
        if (src_q[p].size() < 3 && $urandom_range(99) < 60)
          push_item(p, int'($urandom_range(15)), $urandom);
      step(($urandom_range(39) == 0), 1'b0, 70);
    end
    drain(200);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
